// File: rtl/param_control_unit.sv
// Fetch/decode/execute controller with wait-state memory handshake, bus watchdog, one-level IRQ and HALT.
// Outputs are combinational from state; every memory state stalls while mem_ready is low.
module param_control_unit #(
   parameter int OPCODE_W    = 4,
   parameter int INSTR_BYTES = 2,
   parameter int MAX_WAIT    = 0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [OPCODE_W-1:0]    opcode,
   input  logic                   zero_flag,
   input  logic                   mem_ready,
   input  logic                   irq,
   output logic                   pc_write_enable,
   output logic                   pc_inc,
   output logic [INSTR_BYTES-1:0] ir_write_enable,
   output logic                   acc_write_enable,
   output logic                   z_flag_write_enable,
   output logic                   ram_read_enable,
   output logic                   ram_write_enable,
   output logic [2:0]             alu_op,
   output logic                   addr_bus_select,
   output logic [1:0]             acc_input_select,
   output logic [1:0]             pc_input_select,
   output logic                   data_bus_select,
   output logic                   save_pc,
   output logic                   irq_ack,
   output logic                   halted,
   output logic                   illegal_op,
   output logic                   bus_error
);

   localparam int BC_W   = (INSTR_BYTES > 1) ? $clog2(INSTR_BYTES) : 1;
   localparam int WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
   localparam logic [BC_W-1:0]   LAST_BYTE = BC_W'(INSTR_BYTES - 1);
   localparam logic [WAIT_W-1:0] WAIT_LIM  = WAIT_W'(MAX_WAIT);
   localparam bit                WD_EN     = (MAX_WAIT > 0);

   localparam logic [3:0] OP_LDA  = 4'd1;
   localparam logic [3:0] OP_STA  = 4'd2;
   localparam logic [3:0] OP_ADD  = 4'd3;
   localparam logic [3:0] OP_SUB  = 4'd4;
   localparam logic [3:0] OP_AND  = 4'd5;
   localparam logic [3:0] OP_OR   = 4'd6;
   localparam logic [3:0] OP_XOR  = 4'd7;
   localparam logic [3:0] OP_NOT  = 4'd8;
   localparam logic [3:0] OP_INC  = 4'd9;
   localparam logic [3:0] OP_DEC  = 4'd10;
   localparam logic [3:0] OP_JMP  = 4'd11;
   localparam logic [3:0] OP_JZ   = 4'd12;
   localparam logic [3:0] OP_LDI  = 4'd13;
   localparam logic [3:0] OP_RETI = 4'd14;
   localparam logic [3:0] OP_HLT  = 4'd15;

   typedef enum logic [3:0] {
      S_RST,
      S_FETCH,
      S_DECODE,
      S_EX_MEM_RD,
      S_EX_MEM_WR,
      S_EX_1CYC,
      S_IRQ_SAVE,
      S_IRQ_VEC,
      S_HALT
   } state_t;

   state_t            state_q, state_d;
   logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
   logic              ie_q, ie_d;
   logic [WAIT_W-1:0] wait_q, wait_d;

   // Zero-extend so narrow opcode widths decode the same way and wide ones flag codes above 15.
   logic [OPCODE_W+3:0] op_ext;
   logic [3:0]          op4;
   logic                op_illegal;
   logic [2:0]          alu_sel;
   logic                waiting;
   logic                timeout;

   assign op_ext     = {4'b0000, opcode};
   assign op4        = op_ext[3:0];
   assign op_illegal = |(op_ext >> 4);
   assign alu_sel    = 3'(op4 - OP_ADD);

   assign waiting = (state_q == S_FETCH) || (state_q == S_EX_MEM_RD) || (state_q == S_EX_MEM_WR);
   assign timeout = WD_EN && waiting && (wait_q == WAIT_LIM);

   always_comb begin
      state_d             = state_q;
      byte_cnt_d          = byte_cnt_q;
      ie_d                = ie_q;
      pc_write_enable     = 1'b0;
      pc_inc              = 1'b0;
      ir_write_enable     = '0;
      acc_write_enable    = 1'b0;
      z_flag_write_enable = 1'b0;
      ram_read_enable     = 1'b0;
      ram_write_enable    = 1'b0;
      alu_op              = 3'b000;
      addr_bus_select     = 1'b0;
      acc_input_select    = 2'b00;
      pc_input_select     = 2'b00;
      data_bus_select     = 1'b0;
      save_pc             = 1'b0;
      irq_ack             = 1'b0;
      halted              = 1'b0;
      illegal_op          = 1'b0;
      bus_error           = 1'b0;

      case (state_q)
         S_RST: begin
            state_d    = S_FETCH;
            byte_cnt_d = '0;
         end

         S_FETCH: begin
            if (timeout) begin
               bus_error  = 1'b1;
               byte_cnt_d = '0;
               state_d    = S_HALT;
            end else begin
               ram_read_enable = 1'b1;
               if (mem_ready) begin
                  ir_write_enable = INSTR_BYTES'(1) << byte_cnt_q;
                  pc_inc          = 1'b1;
                  if (byte_cnt_q == LAST_BYTE) begin
                     byte_cnt_d = '0;
                     state_d    = S_DECODE;
                  end else begin
                     byte_cnt_d = byte_cnt_q + 1'b1;
                  end
               end
            end
         end

         S_DECODE: begin
            if (op_illegal) begin
               state_d = S_EX_1CYC;
            end else begin
               case (op4)
                  OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: state_d = S_EX_MEM_RD;
                  OP_STA:                                        state_d = S_EX_MEM_WR;
                  OP_HLT:                                        state_d = S_HALT;
                  default:                                       state_d = S_EX_1CYC;
               endcase
            end
         end

         S_EX_MEM_RD: begin
            if (timeout) begin
               bus_error = 1'b1;
               state_d   = S_HALT;
            end else begin
               ram_read_enable = 1'b1;
               addr_bus_select = 1'b1;
               if (op4 == OP_LDA) begin
                  acc_input_select = 2'b01;
               end else begin
                  alu_op = alu_sel;
               end
               if (mem_ready) begin
                  acc_write_enable    = 1'b1;
                  z_flag_write_enable = (op4 != OP_LDA);
                  state_d             = (irq && ie_d) ? S_IRQ_SAVE : S_FETCH;
               end
            end
         end

         S_EX_MEM_WR: begin
            if (timeout) begin
               bus_error = 1'b1;
               state_d   = S_HALT;
            end else begin
               ram_write_enable = 1'b1;
               addr_bus_select  = 1'b1;
               data_bus_select  = 1'b1;
               if (mem_ready) begin
                  state_d = (irq && ie_d) ? S_IRQ_SAVE : S_FETCH;
               end
            end
         end

         S_EX_1CYC: begin
            if (op_illegal) begin
               illegal_op = 1'b1;
            end else begin
               case (op4)
                  OP_NOT, OP_INC, OP_DEC: begin
                     acc_write_enable    = 1'b1;
                     z_flag_write_enable = 1'b1;
                     alu_op              = alu_sel;
                  end
                  OP_LDI: begin
                     acc_write_enable = 1'b1;
                     acc_input_select = 2'b10;
                  end
                  OP_JMP: begin
                     pc_write_enable = 1'b1;
                     pc_input_select = 2'b01;
                  end
                  OP_JZ: begin
                     pc_write_enable = zero_flag;
                     pc_input_select = zero_flag ? 2'b01 : 2'b00;
                  end
                  OP_RETI: begin
                     pc_write_enable = 1'b1;
                     pc_input_select = 2'b11;
                     ie_d            = 1'b1;
                  end
                  default: ;
               endcase
            end
            // RETI re-enables immediately, so a pending request is taken right after the return.
            state_d = (irq && ie_d) ? S_IRQ_SAVE : S_FETCH;
         end

         S_IRQ_SAVE: begin
            save_pc = 1'b1;
            irq_ack = 1'b1;
            ie_d    = 1'b0;
            state_d = S_IRQ_VEC;
         end

         S_IRQ_VEC: begin
            pc_write_enable = 1'b1;
            pc_input_select = 2'b10;
            state_d         = S_FETCH;
         end

         S_HALT: begin
            halted = 1'b1;
            if (irq && ie_q) begin
               state_d = S_IRQ_SAVE;
            end
         end

         default: state_d = S_RST;
      endcase
   end

   // The watchdog window restarts on each completed access as well as on every state change.
   always_comb begin
      if (!WD_EN || mem_ready || (state_d != state_q)) begin
         wait_d = '0;
      end else if (waiting) begin
         wait_d = wait_q + 1'b1;
      end else begin
         wait_d = wait_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_RST;
         byte_cnt_q <= '0;
         ie_q       <= 1'b1;
         wait_q     <= '0;
      end else begin
         state_q    <= state_d;
         byte_cnt_q <= byte_cnt_d;
         ie_q       <= ie_d;
         wait_q     <= wait_d;
      end
   end

endmodule

// File: tb/tb_param_control_unit.sv
// Scoreboard bench: stimulus queues the hand-derived output vector for each cycle; a negedge monitor compares.
module tb_param_control_unit;

   typedef struct packed {
      logic       pc_we;
      logic       pc_inc;
      logic [1:0] ir_we;
      logic       acc_we;
      logic       z_we;
      logic       rre;
      logic       rwe;
      logic [2:0] alu;
      logic       abs;
      logic [1:0] ais;
      logic [1:0] pis;
      logic       dbs;
      logic       save;
      logic       ack;
      logic       halted;
      logic       ill;
      logic       berr;
   } ovec_t;

   localparam ovec_t Z = '0;

   logic clk;
   logic reset0, zf0, mr0, irq0;
   logic reset1, zf1, mr1, irq1;
   logic [3:0] opcode0;
   logic [4:0] opcode1;

   logic       pc_write_enable0, pc_inc0, acc_write_enable0, z_flag_write_enable0;
   logic       ram_read_enable0, ram_write_enable0, addr_bus_select0, data_bus_select0;
   logic       save_pc0, irq_ack0, halted0, illegal_op0, bus_error0;
   logic [1:0] ir_write_enable0, acc_input_select0, pc_input_select0;
   logic [2:0] alu_op0;

   logic       pc_write_enable1, pc_inc1, acc_write_enable1, z_flag_write_enable1;
   logic       ram_read_enable1, ram_write_enable1, addr_bus_select1, data_bus_select1;
   logic       save_pc1, irq_ack1, halted1, illegal_op1, bus_error1;
   logic [1:0] ir_write_enable1, acc_input_select1, pc_input_select1;
   logic [2:0] alu_op1;

   ovec_t act0, act1;
   ovec_t exp_q[$];
   bit    dut_q[$];
   string tag_q[$];
   int    checks = 0;
   int    failures = 0;

   param_control_unit #(.OPCODE_W(4), .INSTR_BYTES(2), .MAX_WAIT(0)) u0 (
      .clk(clk), .reset(reset0), .opcode(opcode0), .zero_flag(zf0), .mem_ready(mr0), .irq(irq0),
      .pc_write_enable(pc_write_enable0), .pc_inc(pc_inc0), .ir_write_enable(ir_write_enable0),
      .acc_write_enable(acc_write_enable0), .z_flag_write_enable(z_flag_write_enable0),
      .ram_read_enable(ram_read_enable0), .ram_write_enable(ram_write_enable0), .alu_op(alu_op0),
      .addr_bus_select(addr_bus_select0), .acc_input_select(acc_input_select0),
      .pc_input_select(pc_input_select0), .data_bus_select(data_bus_select0), .save_pc(save_pc0),
      .irq_ack(irq_ack0), .halted(halted0), .illegal_op(illegal_op0), .bus_error(bus_error0)
   );

   param_control_unit #(.OPCODE_W(5), .INSTR_BYTES(2), .MAX_WAIT(5)) u1 (
      .clk(clk), .reset(reset1), .opcode(opcode1), .zero_flag(zf1), .mem_ready(mr1), .irq(irq1),
      .pc_write_enable(pc_write_enable1), .pc_inc(pc_inc1), .ir_write_enable(ir_write_enable1),
      .acc_write_enable(acc_write_enable1), .z_flag_write_enable(z_flag_write_enable1),
      .ram_read_enable(ram_read_enable1), .ram_write_enable(ram_write_enable1), .alu_op(alu_op1),
      .addr_bus_select(addr_bus_select1), .acc_input_select(acc_input_select1),
      .pc_input_select(pc_input_select1), .data_bus_select(data_bus_select1), .save_pc(save_pc1),
      .irq_ack(irq_ack1), .halted(halted1), .illegal_op(illegal_op1), .bus_error(bus_error1)
   );

   assign act0 = {pc_write_enable0, pc_inc0, ir_write_enable0, acc_write_enable0, z_flag_write_enable0,
                  ram_read_enable0, ram_write_enable0, alu_op0, addr_bus_select0, acc_input_select0,
                  pc_input_select0, data_bus_select0, save_pc0, irq_ack0, halted0, illegal_op0, bus_error0};
   assign act1 = {pc_write_enable1, pc_inc1, ir_write_enable1, acc_write_enable1, z_flag_write_enable1,
                  ram_read_enable1, ram_write_enable1, alu_op1, addr_bus_select1, acc_input_select1,
                  pc_input_select1, data_bus_select1, save_pc1, irq_ack1, halted1, illegal_op1, bus_error1};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic ovec_t f_fetch(input int b, input bit rdy);
      ovec_t e = '0;
      e.rre = 1'b1;
      if (rdy) begin
         e.ir_we  = (b == 0) ? 2'b01 : 2'b10;
         e.pc_inc = 1'b1;
      end
      return e;
   endfunction

   function automatic ovec_t f_mrd(input bit lda, input logic [2:0] alu, input bit rdy);
      ovec_t e = '0;
      e.rre = 1'b1;
      e.abs = 1'b1;
      if (lda) e.ais = 2'b01;
      else     e.alu = alu;
      if (rdy) begin
         e.acc_we = 1'b1;
         e.z_we   = !lda;
      end
      return e;
   endfunction

   function automatic ovec_t f_mwr();
      ovec_t e = '0;
      e.rwe = 1'b1;
      e.abs = 1'b1;
      e.dbs = 1'b1;
      return e;
   endfunction

   function automatic ovec_t f_ex(input bit pcwe, input logic [1:0] pis, input bit accwe,
                                  input bit zwe, input logic [2:0] alu, input logic [1:0] ais);
      ovec_t e = '0;
      e.pc_we  = pcwe;
      e.pis    = pis;
      e.acc_we = accwe;
      e.z_we   = zwe;
      e.alu    = alu;
      e.ais    = ais;
      return e;
   endfunction

   function automatic ovec_t f_save();
      ovec_t e = '0;
      e.save = 1'b1;
      e.ack  = 1'b1;
      return e;
   endfunction

   function automatic ovec_t f_stat(input bit h, input bit il, input bit be);
      ovec_t e = '0;
      e.halted = h;
      e.ill    = il;
      e.berr   = be;
      return e;
   endfunction

   task automatic cyc(input bit d, input string t, input ovec_t e);
      exp_q.push_back(e);
      dut_q.push_back(d);
      tag_q.push_back(t);
      @(posedge clk);
      #1;
   endtask

   task automatic fetch2(input bit d, input string t);
      cyc(d, {t, "_f0"}, f_fetch(0, 1'b1));
      cyc(d, {t, "_f1"}, f_fetch(1, 1'b1));
      cyc(d, {t, "_dec"}, Z);
   endtask

   ovec_t m_e, m_a;
   bit    m_d;
   string m_t;

   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         m_e = exp_q.pop_front();
         m_d = dut_q.pop_front();
         m_t = tag_q.pop_front();
         m_a = m_d ? act1 : act0;
         checks++;
         if (m_a !== m_e) begin
            failures++;
            $display("FAIL %s: outputs got %h expected %h", m_t, m_a, m_e);
         end
      end
   end

   initial begin
      reset0 = 1'b0; zf0 = 1'b0; mr0 = 1'b1; irq0 = 1'b0; opcode0 = 4'd0;
      reset1 = 1'b0; zf1 = 1'b0; mr1 = 1'b1; irq1 = 1'b0; opcode1 = 5'd0;
      @(posedge clk);
      #1;

      cyc(0, "rst_hold", Z);
      cyc(0, "rst_hold2", Z);
      reset0 = 1'b1;
      cyc(0, "rst_idle", Z);

      opcode0 = 4'd3;
      fetch2(0, "add");
      cyc(0, "add_ex", f_mrd(1'b0, 3'b000, 1'b1));

      opcode0 = 4'd1;
      cyc(0, "lda_f0", f_fetch(0, 1'b1));
      mr0 = 1'b0;
      cyc(0, "lda_f1_wait", f_fetch(1, 1'b0));
      mr0 = 1'b1;
      cyc(0, "lda_f1", f_fetch(1, 1'b1));
      cyc(0, "lda_dec", Z);
      mr0 = 1'b0;
      repeat (3) cyc(0, "lda_wait", f_mrd(1'b1, 3'b000, 1'b0));
      mr0 = 1'b1;
      cyc(0, "lda_done", f_mrd(1'b1, 3'b000, 1'b1));

      opcode0 = 4'd4;
      fetch2(0, "sub");
      cyc(0, "sub_ex", f_mrd(1'b0, 3'b001, 1'b1));
      opcode0 = 4'd7;
      fetch2(0, "xor");
      cyc(0, "xor_ex", f_mrd(1'b0, 3'b100, 1'b1));

      opcode0 = 4'd2;
      fetch2(0, "sta");
      mr0 = 1'b0;
      cyc(0, "sta_wait", f_mwr());
      mr0 = 1'b1;
      cyc(0, "sta_done", f_mwr());

      opcode0 = 4'd13;
      fetch2(0, "ldi");
      cyc(0, "ldi_ex", f_ex(1'b0, 2'b00, 1'b1, 1'b0, 3'b000, 2'b10));
      opcode0 = 4'd8;
      fetch2(0, "not");
      cyc(0, "not_ex", f_ex(1'b0, 2'b00, 1'b1, 1'b1, 3'b101, 2'b00));
      opcode0 = 4'd10;
      fetch2(0, "dec");
      cyc(0, "dec_ex", f_ex(1'b0, 2'b00, 1'b1, 1'b1, 3'b111, 2'b00));
      opcode0 = 4'd11;
      fetch2(0, "jmp");
      cyc(0, "jmp_ex", f_ex(1'b1, 2'b01, 1'b0, 1'b0, 3'b000, 2'b00));
      zf0 = 1'b1;
      opcode0 = 4'd12;
      fetch2(0, "jz_t");
      cyc(0, "jz_t_ex", f_ex(1'b1, 2'b01, 1'b0, 1'b0, 3'b000, 2'b00));

      // Interrupt raised mid-JZ with Z clear; held high so the nested request must wait for RETI.
      zf0 = 1'b0;
      cyc(0, "jz_nt_f0", f_fetch(0, 1'b1));
      irq0 = 1'b1;
      cyc(0, "jz_nt_f1", f_fetch(1, 1'b1));
      cyc(0, "jz_nt_dec", Z);
      cyc(0, "jz_nt_ex", Z);
      cyc(0, "irq1_save", f_save());
      cyc(0, "irq1_vec", f_ex(1'b1, 2'b10, 1'b0, 1'b0, 3'b000, 2'b00));
      opcode0 = 4'd0;
      fetch2(0, "nop_masked");
      cyc(0, "nop_masked_ex", Z);
      opcode0 = 4'd14;
      fetch2(0, "reti1");
      cyc(0, "reti1_ex", f_ex(1'b1, 2'b11, 1'b0, 1'b0, 3'b000, 2'b00));
      cyc(0, "irq2_save", f_save());
      cyc(0, "irq2_vec", f_ex(1'b1, 2'b10, 1'b0, 1'b0, 3'b000, 2'b00));
      irq0 = 1'b0;
      fetch2(0, "reti2");
      cyc(0, "reti2_ex", f_ex(1'b1, 2'b11, 1'b0, 1'b0, 3'b000, 2'b00));

      opcode0 = 4'd15;
      fetch2(0, "hlt");
      repeat (20) cyc(0, "halt_hold", f_stat(1'b1, 1'b0, 1'b0));
      irq0 = 1'b1;
      cyc(0, "halt_irq", f_stat(1'b1, 1'b0, 1'b0));
      cyc(0, "halt_save", f_save());
      cyc(0, "halt_vec", f_ex(1'b1, 2'b10, 1'b0, 1'b0, 3'b000, 2'b00));
      irq0 = 1'b0;

      opcode0 = 4'd2;
      fetch2(0, "sta_rst");
      mr0 = 1'b0;
      cyc(0, "sta_rst_wait", f_mwr());
      reset0 = 1'b0;
      cyc(0, "rst_mid_wr", Z);
      mr0 = 1'b1;
      reset0 = 1'b1;
      cyc(0, "rst_rel", Z);
      opcode0 = 4'd0;
      cyc(0, "post_rst_f0", f_fetch(0, 1'b1));
      irq0 = 1'b1;
      cyc(0, "post_rst_f1", f_fetch(1, 1'b1));
      cyc(0, "post_rst_dec", Z);
      cyc(0, "post_rst_ex", Z);
      cyc(0, "ie_reset_save", f_save());
      cyc(0, "ie_reset_vec", f_ex(1'b1, 2'b10, 1'b0, 1'b0, 3'b000, 2'b00));
      irq0 = 1'b0;
      cyc(0, "ie_reset_f0", f_fetch(0, 1'b1));

      cyc(1, "u1_rst", Z);
      reset1 = 1'b1;
      cyc(1, "u1_idle", Z);
      opcode1 = 5'd17;
      fetch2(1, "ill");
      cyc(1, "ill_ex", f_stat(1'b0, 1'b1, 1'b0));
      opcode1 = 5'd3;
      fetch2(1, "add_late");
      mr1 = 1'b0;
      repeat (4) cyc(1, "add_late_wait", f_mrd(1'b0, 3'b000, 1'b0));
      mr1 = 1'b1;
      cyc(1, "add_late_done", f_mrd(1'b0, 3'b000, 1'b1));
      fetch2(1, "add_stuck");
      mr1 = 1'b0;
      repeat (5) cyc(1, "add_stuck_wait", f_mrd(1'b0, 3'b000, 1'b0));
      cyc(1, "wd_rd_berr", f_stat(1'b0, 1'b0, 1'b1));
      repeat (3) cyc(1, "wd_rd_halt", f_stat(1'b1, 1'b0, 1'b0));

      reset1 = 1'b0;
      cyc(1, "u1_rst2", Z);
      reset1 = 1'b1;
      cyc(1, "u1_idle2", Z);
      repeat (5) cyc(1, "fetch_stuck", f_fetch(0, 1'b0));
      cyc(1, "wd_fetch_berr", f_stat(1'b0, 1'b0, 1'b1));
      repeat (3) cyc(1, "wd_fetch_halt", f_stat(1'b1, 1'b0, 1'b0));

      repeat (3) @(negedge clk);
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: pending %0d required 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/param_control_unit.md
# param_control_unit

Parametrised next-generation control unit for the 8-bit microcontroller: a Fetch-Decode-Execute FSM with configurable instruction length and opcode width. It adds a wait-state memory handshake, a bus-timeout watchdog, a single-level maskable interrupt with PC save and return, and a HALT state. It sits between the instruction register and opcode decoder on one side and the PC, IR, accumulator, ALU, RAM and bus muxes on the other.

## Interface
- OPCODE_W, 4: opcode width. Codes 0–15 are defined; any other code is illegal.
- INSTR_BYTES, 2: bytes fetched per instruction, legal range 1–4.
- MAX_WAIT, 0: maximum cycles to wait for mem_ready. 0 disables the watchdog.
- clk  in  1  system clock; every register updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- opcode  in  OPCODE_W  opcode field from the IR.
- zero_flag  in  1  registered Z flag.
- mem_ready  in  1  RAM access completes in any cycle where this is high.
- irq  in  1  level-sensitive interrupt request.
- pc_write_enable, pc_inc  out  1  PC load and PC increment.
- ir_write_enable  out  INSTR_BYTES  per-byte IR load. Bit 0 is the first fetched byte.
- acc_write_enable, z_flag_write_enable  out  1  accumulator load and Z flag update.
- ram_read_enable, ram_write_enable  out  1  RAM strobes, held high until mem_ready.
- alu_op  out  3  ALU operation select.
- addr_bus_select  out  1  address bus source: 0 = PC, 1 = IR operand.
- acc_input_select  out  2  accumulator source: 00 = ALU, 01 = RAM, 10 = IR immediate.
- pc_input_select  out  2  PC load source: 00 = increment, 01 = IR operand, 10 = interrupt vector, 11 = shadow PC.
- data_bus_select  out  1  data bus driver: 1 = accumulator drives RAM data.
- save_pc, irq_ack  out  1  copy PC into the shadow register; interrupt acknowledge.
- halted, illegal_op, bus_error  out  1  status outputs.

## Operation
- Opcode map and alu_op encoding:
  - 0 NOP
  - 1 LDA, 2 STA
  - 3 ADD (000), 4 SUB (001), 5 AND (010), 6 OR (011), 7 XOR (100)
  - 8 NOT (101), 9 INC (110), 10 DEC (111)
  - 11 JMP, 12 JZ, 13 LDI, 14 RETI, 15 HLT
- States: RST, FETCH, DECODE, EX_MEM_RD, EX_MEM_WR, EX_1CYC, IRQ_SAVE, IRQ_VEC, HALT.
- Internal registers:
  - byte counter for the fetch byte index;
  - ie, the interrupt-enable flag, set to 1 by reset;
  - wait counter for the watchdog.
- All outputs default to 0. Each state asserts only the signals listed below.
- RST: all outputs 0 for one cycle, then go to FETCH with byte counter = 0.
- FETCH:
  - Assert ram_read_enable with addr_bus_select = 0.
  - On a cycle with mem_ready high, also assert ir_write_enable[byte counter] and pc_inc, then advance the byte counter.
  - After byte INSTR_BYTES-1 is written, go to DECODE.
- DECODE: no outputs asserted. Branch on opcode:
  - LDA and ADD through XOR go to EX_MEM_RD.
  - STA goes to EX_MEM_WR.
  - HLT goes to HALT.
  - Every other opcode goes to EX_1CYC.
- EX_MEM_RD:
  - Assert ram_read_enable with addr_bus_select = 1.
  - On mem_ready, assert acc_write_enable.
  - LDA: acc_input_select = 01 and Z is not updated.
  - ALU ops: acc_input_select = 00, alu_op per the map, z_flag_write_enable = 1.
- EX_MEM_WR: assert ram_write_enable, addr_bus_select = 1 and data_bus_select = 1 until mem_ready.
- EX_1CYC, by opcode:
  - NOT, INC, DEC: acc_write_enable, acc_input_select = 00, alu_op per the map, z_flag_write_enable.
  - LDI: acc_write_enable with acc_input_select = 10.
  - JMP: pc_write_enable with pc_input_select = 01.
  - JZ: the same as JMP, asserted only when zero_flag = 1.
  - RETI: pc_write_enable with pc_input_select = 11, and set ie = 1.
  - NOP: no outputs.
  - Illegal opcode: treat as NOP and pulse illegal_op for one cycle.
- Instruction boundary: when an execute state completes, go to IRQ_SAVE if irq && ie, otherwise to FETCH.
- IRQ_SAVE: assert save_pc and irq_ack for one cycle and clear ie.
- IRQ_VEC: pc_write_enable with pc_input_select = 10, then go to FETCH.
- HALT: halted = 1. Stay in HALT until irq && ie, then go to IRQ_SAVE. The saved PC points to the instruction after HLT.
- Watchdog (MAX_WAIT > 0): in any state waiting on mem_ready, count the cycles in which mem_ready is low. When the count reaches MAX_WAIT:
  - drop the strobe;
  - pulse bus_error for one cycle;
  - go to HALT.
  - The counter clears on every state change.

## Timing
- While reset is low: state = RST and all outputs are 0, including halted.
- The first fetch strobe appears 1 cycle after reset is released.
- Cycles per instruction with mem_ready tied high:
  - memory instructions (LDA, STA, ADD–XOR): INSTR_BYTES + 2;
  - one-cycle instructions: INSTR_BYTES + 2;
  - interrupt entry: +2.
- Each low cycle of mem_ready adds exactly one cycle. Strobes and address selects stay stable throughout the wait.
- Control outputs are combinational from the state. The completion strobes (ir_write_enable, pc_inc, acc_write_enable, z_flag_write_enable) are additionally gated by mem_ready in the same cycle.
- irq is sampled only at instruction boundaries and in HALT. An irq that goes high mid-instruction is taken after the current instruction completes.
- irq && !ie: the request is ignored and the controller continues with FETCH.
- Asynchronous reset mid-instruction aborts at once: state = RST, byte counter = 0, ie = 1, wait counter = 0.

## Test plan
- ADD with mem_ready tied high, INSTR_BYTES = 2: acc_write_enable, z_flag_write_enable and alu_op = 000 are asserted exactly in cycle 4. The instruction takes 4 cycles in total.
- LDA with mem_ready low for 3 cycles: ram_read_enable and addr_bus_select = 1 hold for 4 cycles. acc_write_enable pulses once, in the cycle mem_ready goes high.
- irq raised during a JZ with zero_flag = 0: the PC is not loaded. irq_ack and save_pc pulse one cycle after EX_1CYC, then pc_input_select = 10. A second irq is ignored until RETI executes, then taken.
- HLT: halted stays 1 for 20 cycles. On irq, halted drops and the IRQ_SAVE then IRQ_VEC sequence runs.
- MAX_WAIT = 5 with mem_ready stuck low in FETCH: bus_error pulses after 5 waiting cycles, then halted = 1.
- Reset asserted in the middle of EX_MEM_WR: ram_write_enable drops within the same cycle. After release, one cycle of all-zero outputs, then the FETCH of byte 0.
